ascii_hex_parser: RTL and testbench
===================================

# ascii_hex_parser

Streaming ASCII-hex word parser for the UART receive path. It consumes one byte per valid/ready handshake from the UART RX FIFO and assembles hexadecimal digits into a DATA_W-bit word. It handles optional "0x" prefixes, case selection, terminator delimiting, overflow and invalid-character errors. The assembled word is presented on a valid/ready output port to the command decoder. It replaces the single-byte combinational ASCII-to-hex conversion with a full word-level engine.

## Interface
- DATA_W, 32, output word width; multiple of 4, range 4..64; MAX_DIG = DATA_W/4 (localparam)
- LOWER_CASE, 1, 1 = accept 'a'..'f' as digits; 0 = lowercase letters are invalid
- ALLOW_PREFIX, 1, 1 = a leading "0x"/"0X" is skipped; 0 = 'x'/'X' is invalid
- clk  in  1  single clock; all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  8  ASCII byte
- in_valid  in  1  in_data valid
- in_ready  out  1  byte accepted when in_valid && in_ready
- out_data  out  DATA_W  parsed word, zero-extended
- out_digits  out  $clog2(MAX_DIG+1)  number of digits accumulated (prefix excluded)
- out_err  out  1  word is invalid; out_data = 0 and out_digits = 0 when set
- out_valid  out  1  word pending
- out_ready  in  1  word consumed when out_valid && out_ready

## Operation
- Byte classes:
  - DIGIT: '0'-'9', 'A'-'F', and 'a'-'f' if LOWER_CASE.
  - TERM: 0x0D, 0x0A, 0x20, 0x2C.
  - X: 'x'/'X' if ALLOW_PREFIX.
  - BAD: everything else.
- States: IDLE, ZERO, ACC, SKIP, HOLD.
- IDLE:
  - TERM: ignored; empty words are never emitted.
  - DIGIT '0' with ALLOW_PREFIX: acc=0, cnt=1, go to ZERO.
  - Other DIGIT: acc=d, cnt=1, go to ACC.
  - X or BAD: go to SKIP.
- ZERO:
  - X: acc=0, cnt=0, go to ACC.
  - DIGIT: acc=d, cnt=2, go to ACC.
  - TERM: emit 0, digits=1.
  - BAD: go to SKIP.
- ACC:
  - DIGIT with cnt<MAX_DIG: acc=(acc<<4)|d, cnt+1.
  - DIGIT with cnt==MAX_DIG: overflow, go to SKIP.
  - TERM with cnt>0: emit acc, cnt.
  - TERM with cnt==0 (bare "0x"): emit error.
  - X or BAD: go to SKIP.
- SKIP: discard bytes until TERM, then emit error.
- Emit: load the output registers, set out_valid, go to HOLD.
- HOLD: out_valid stays high; exit to IDLE on out_valid && out_ready.
- Leading zeros count toward cnt and toward overflow.
- The terminator byte is consumed and is not part of the next word.

## Timing
- Reset values:
  - state = IDLE; acc = 0; cnt = 0.
  - out_data = 0, out_digits = 0, out_err = 0, out_valid = 0.
  - in_ready = 1 while in reset and after it.
- in_ready = !out_valid (combinational). No byte is accepted while a word is pending.
- Latency: a TERM accepted at edge N gives out_valid = 1 after edge N. The output is registered and carries no combinational path from in_*.
- The output handshake at edge M clears out_valid after M. in_ready rises in the same cycle, so the next byte can be accepted at edge M+1.
- Back-pressure: while out_ready = 0, out_data, out_digits and out_err hold stable and out_valid stays high.
- Reset mid-word or mid-HOLD: the partial or pending word is dropped and no output is produced.
- acc is held at DATA_W bits; the shift never exceeds the width because overflow is caught before the shift.

## Structure
- ASCII constants (digits, letters, CR, LF, SPACE, COMMA, 'x'/'X') come from the shared uart_defines include. The TERM set is also defined there.
- Sub-module ascii_hex_classify: combinational; in_data plus LOWER_CASE and ALLOW_PREFIX produce class[1:0] and nibble[3:0].
- The parser holds the FSM, accumulator, counter and output registers. Expected size is about 200 lines.

## Test plan
- "\r\n1A2b\r" (LOWER_CASE=1, DATA_W=32) -> exactly one word: out_data=0x00001A2B, out_digits=4, out_err=0. The leading terminators produce no output.
- "0xFF " -> 0x000000FF, digits=2. "0\n" -> 0x0, digits=1. "0x\n" -> out_err=1, out_data=0.
- "123456789," (DATA_W=32) -> out_err=1. The following "7\n" -> 0x7, digits=1, err=0.
- "12G4\r" -> out_err=1. With LOWER_CASE=0, "ab\r" -> out_err=1. With ALLOW_PREFIX=0, "0x5\r" -> out_err=1.
- "3C\r" with out_ready held low for 5 cycles:
  - out_valid and out_data=0x3C stay stable, and in_ready=0 throughout.
  - After the handshake edge, the next byte is accepted one edge later.
- "12", then a 2-cycle rst_n low pulse, then "3\r" -> the only word emitted is 0x3, digits=1. All outputs are 0 during reset.

Source files
------------

// File: rtl/ascii_hex_parser_pkg.sv
// Shared definitions for the ASCII-hex word parser: byte classes, parser states
// and the ASCII constants of the UART receive path.
package ascii_hex_parser_pkg;

  localparam logic [7:0] CHR_0     = 8'h30;
  localparam logic [7:0] CHR_9     = 8'h39;
  localparam logic [7:0] CHR_UP_A  = 8'h41;
  localparam logic [7:0] CHR_UP_F  = 8'h46;
  localparam logic [7:0] CHR_LOW_A = 8'h61;
  localparam logic [7:0] CHR_LOW_F = 8'h66;
  localparam logic [7:0] CHR_UP_X  = 8'h58;
  localparam logic [7:0] CHR_LOW_X = 8'h78;
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_LF    = 8'h0A;
  localparam logic [7:0] CHR_SPACE = 8'h20;
  localparam logic [7:0] CHR_COMMA = 8'h2C;

  typedef enum logic [1:0] {
    CLS_DIGIT,
    CLS_TERM,
    CLS_X,
    CLS_BAD
  } byte_class_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ZERO,
    ST_ACC,
    ST_SKIP,
    ST_HOLD
  } parse_state_e;

  function automatic logic is_term(input logic [7:0] b);
    return (b == CHR_CR) || (b == CHR_LF) || (b == CHR_SPACE) || (b == CHR_COMMA);
  endfunction

endpackage

// File: rtl/ascii_hex_classify.sv
// Combinational byte classifier: maps an ASCII byte to DIGIT/TERM/X/BAD and,
// for digits, the 4-bit value.
module ascii_hex_classify
  import ascii_hex_parser_pkg::*;
#(
  parameter bit LOWER_CASE   = 1'b1,
  parameter bit ALLOW_PREFIX = 1'b1
) (
  input  logic [7:0]  in_data,
  output byte_class_e byte_class,
  output logic [3:0]  nibble
);

  always_comb begin
    byte_class = CLS_BAD;
    nibble     = 4'd0;
    if (in_data >= CHR_0 && in_data <= CHR_9) begin
      byte_class = CLS_DIGIT;
      nibble     = in_data[3:0];
    end else if (in_data >= CHR_UP_A && in_data <= CHR_UP_F) begin
      byte_class = CLS_DIGIT;
      nibble     = in_data[3:0] + 4'd9;
    end else if (LOWER_CASE && in_data >= CHR_LOW_A && in_data <= CHR_LOW_F) begin
      byte_class = CLS_DIGIT;
      nibble     = in_data[3:0] + 4'd9;
    end else if (is_term(in_data)) begin
      byte_class = CLS_TERM;
    end else if (ALLOW_PREFIX && (in_data == CHR_UP_X || in_data == CHR_LOW_X)) begin
      byte_class = CLS_X;
    end
  end

endmodule

// File: rtl/ascii_hex_parser.sv
// Streaming ASCII-hex word parser: assembles hex digits into a DATA_W-bit word
// delimited by terminators, flagging overflow and invalid characters.
module ascii_hex_parser
  import ascii_hex_parser_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter bit LOWER_CASE   = 1'b1,
  parameter bit ALLOW_PREFIX = 1'b1,
  localparam int MAX_DIG     = DATA_W / 4,
  localparam int CNT_W       = $clog2(MAX_DIG + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_digits,
  output logic              out_err,
  output logic              out_valid,
  input  logic              out_ready
);

  byte_class_e byte_class;
  logic [3:0]  nibble;

  parse_state_e      state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  out_digits_q, out_digits_d;
  logic              out_err_q, out_err_d;
  logic              out_valid_q, out_valid_d;
  logic              accept, emit_ok, emit_err;

  ascii_hex_classify #(
    .LOWER_CASE  (LOWER_CASE),
    .ALLOW_PREFIX(ALLOW_PREFIX)
  ) u_classify (
    .in_data   (in_data),
    .byte_class(byte_class),
    .nibble    (nibble)
  );

  assign in_ready = !out_valid_q;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    out_data_d   = out_data_q;
    out_digits_d = out_digits_q;
    out_err_d    = out_err_q;
    out_valid_d  = out_valid_q;
    emit_ok      = 1'b0;
    emit_err     = 1'b0;

    unique case (state_q)
      ST_IDLE: if (accept) begin
        unique case (byte_class)
          CLS_DIGIT: begin
            acc_d   = DATA_W'(nibble);
            cnt_d   = CNT_W'(1);
            state_d = (ALLOW_PREFIX && nibble == 4'd0) ? ST_ZERO : ST_ACC;
          end
          CLS_TERM: state_d = ST_IDLE;
          default:  state_d = ST_SKIP;
        endcase
      end
      ST_ZERO: if (accept) begin
        unique case (byte_class)
          CLS_X: begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ST_ACC;
          end
          CLS_DIGIT: begin
            // The leading '0' already counts as one digit.
            if (MAX_DIG >= 2) begin
              acc_d   = DATA_W'(nibble);
              cnt_d   = CNT_W'(2);
              state_d = ST_ACC;
            end else begin
              state_d = ST_SKIP;
            end
          end
          CLS_TERM: emit_ok = 1'b1;
          default:  state_d = ST_SKIP;
        endcase
      end
      ST_ACC: if (accept) begin
        unique case (byte_class)
          CLS_DIGIT: begin
            if (cnt_q < CNT_W'(MAX_DIG)) begin
              acc_d = (acc_q << 4) | DATA_W'(nibble);
              cnt_d = cnt_q + CNT_W'(1);
            end else begin
              state_d = ST_SKIP;
            end
          end
          CLS_TERM: begin
            if (cnt_q != '0) emit_ok = 1'b1;
            else             emit_err = 1'b1;
          end
          default: state_d = ST_SKIP;
        endcase
      end
      ST_SKIP: if (accept && byte_class == CLS_TERM) emit_err = 1'b1;
      ST_HOLD: if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (emit_ok || emit_err) begin
      out_data_d   = emit_ok ? acc_q : '0;
      out_digits_d = emit_ok ? cnt_q : '0;
      out_err_d    = emit_err;
      out_valid_d  = 1'b1;
      acc_d        = '0;
      cnt_d        = '0;
      state_d      = ST_HOLD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      out_data_q   <= '0;
      out_digits_q <= '0;
      out_err_q    <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      out_data_q   <= out_data_d;
      out_digits_q <= out_digits_d;
      out_err_q    <= out_err_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_digits = out_digits_q;
  assign out_err    = out_err_q;
  assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_ascii_hex_parser.sv
// Self-checking bench for ascii_hex_parser: three parameter variants share the
// byte bus; a scoreboard queue holds expected words, popped at each handshake.
module tb_ascii_hex_parser;

  typedef struct {
    int          sel;
    logic [31:0] data;
    logic [3:0]  digits;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        out_ready;
  logic        iv   [3];
  logic        ir   [3];
  logic [31:0] od   [3];
  logic [3:0]  odig [3];
  logic        oerr [3];
  logic        ov   [3];

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;

  // sel 0: defaults, sel 1: uppercase only, sel 2: no "0x" prefix
  ascii_hex_parser #(.DATA_W(32), .LOWER_CASE(1'b1), .ALLOW_PREFIX(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(iv[0]), .in_ready(ir[0]),
    .out_data(od[0]), .out_digits(odig[0]), .out_err(oerr[0]), .out_valid(ov[0]),
    .out_ready(out_ready));

  ascii_hex_parser #(.DATA_W(32), .LOWER_CASE(1'b0), .ALLOW_PREFIX(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(iv[1]), .in_ready(ir[1]),
    .out_data(od[1]), .out_digits(odig[1]), .out_err(oerr[1]), .out_valid(ov[1]),
    .out_ready(out_ready));

  ascii_hex_parser #(.DATA_W(32), .LOWER_CASE(1'b1), .ALLOW_PREFIX(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(iv[2]), .in_ready(ir[2]),
    .out_data(od[2]), .out_digits(odig[2]), .out_err(oerr[2]), .out_valid(ov[2]),
    .out_ready(out_ready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every word that completes a handshake must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      for (int s = 0; s < 3; s++) begin
        if (ov[s] && out_ready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL unexpected_word dut%0d: got data=%h digits=%0d err=%0b, required none",
                     s, od[s], odig[s], oerr[s]);
          end else begin
            e = exp_q.pop_front();
            if (e.sel != s || od[s] !== e.data || odig[s] !== e.digits || oerr[s] !== e.err) begin
              n_fail++;
              $display("[TB] FAIL word dut%0d: got data=%h digits=%0d err=%0b, required dut%0d data=%h digits=%0d err=%0b",
                       s, od[s], odig[s], oerr[s], e.sel, e.data, e.digits, e.err);
            end
          end
        end
      end
    end
  end

  task automatic push_exp(input int sel, input logic [31:0] data, input logic [3:0] digits,
                          input logic err);
    exp_t e;
    e.sel = sel; e.data = data; e.digits = digits; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b);
    bit got;
    got = 1'b0;
    in_data = b;
    iv[sel] = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ir[sel]) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      @(posedge clk);
      #1;
    end else begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL send_timeout dut%0d: in_ready stayed 0, required 1", sel);
    end
    iv[sel] = 1'b0;
  endtask

  task automatic send_str(input int sel, input string s);
    for (int i = 0; i < s.len(); i++) send_byte(sel, s[i]);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain: %0d words still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b1;
    in_data = 8'h00;
    for (int s = 0; s < 3; s++) iv[s] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (ov[0] !== 1'b0 || od[0] !== 32'h0 || odig[0] !== 4'd0 || oerr[0] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got valid=%0b data=%h digits=%0d err=%0b, required all 0",
               ov[0], od[0], odig[0], oerr[0]);
    end
    n_checks++;
    if (ir[0] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_in_ready: got %0b, required 1", ir[0]);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    push_exp(0, 32'h0000_1A2B, 4'd4, 1'b0);
    send_str(0, "\r\n1A2b\r");
    wait_drain();
    push_exp(0, 32'h0000_00FF, 4'd2, 1'b0);
    push_exp(0, 32'h0, 4'd1, 1'b0);
    push_exp(0, 32'h0, 4'd0, 1'b1);
    push_exp(0, 32'h0000_000A, 4'd2, 1'b0);
    push_exp(0, 32'hFFFF_FFFF, 4'd8, 1'b0);
    send_str(0, "0xFF 0\n0x\n0a\rFFFFFFFF\r");
    wait_drain();
  endtask

  task automatic test_overflow();
    push_exp(0, 32'h0, 4'd0, 1'b1);
    push_exp(0, 32'h7, 4'd1, 1'b0);
    push_exp(0, 32'h0, 4'd0, 1'b1);
    send_str(0, "123456789,7\n0x123456789\r");
    wait_drain();
  endtask

  task automatic test_bad_char();
    push_exp(0, 32'h0, 4'd0, 1'b1);
    push_exp(0, 32'h0, 4'd0, 1'b1);
    send_str(0, "12G4\rx1\r");
    push_exp(1, 32'h0, 4'd0, 1'b1);
    push_exp(1, 32'hAB, 4'd2, 1'b0);
    send_str(1, "ab\rAB\r");
    push_exp(2, 32'h0, 4'd0, 1'b1);
    push_exp(2, 32'h5, 4'd2, 1'b0);
    send_str(2, "0x5\r05\r");
    wait_drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    push_exp(0, 32'h3C, 4'd2, 1'b0);
    send_str(0, "3C\r");
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if (ov[0] !== 1'b1 || od[0] !== 32'h3C || odig[0] !== 4'd2 || ir[0] !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL backpressure_hold: got valid=%0b data=%h digits=%0d in_ready=%0b, required 1/3c/2/0",
                 ov[0], od[0], odig[0], ir[0]);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL handshake_release: got valid=%0b in_ready=%0b, required 0/1", ov[0], ir[0]);
    end
    push_exp(0, 32'h5, 4'd1, 1'b0);
    send_str(0, "5\r");
    wait_drain();
  endtask

  task automatic test_back_to_back();
    push_exp(0, 32'h1, 4'd1, 1'b0);
    push_exp(0, 32'h2, 4'd1, 1'b0);
    push_exp(0, 32'hDEAD, 4'd4, 1'b0);
    send_str(0, "1,2,,dEaD\r");
    wait_drain();
  endtask

  task automatic test_reset_mid_word();
    send_str(0, "12");
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (ov[0] !== 1'b0 || od[0] !== 32'h0 || odig[0] !== 4'd0 || oerr[0] !== 1'b0 || ir[0] !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL reset_mid_word: got valid=%0b data=%h digits=%0d err=%0b in_ready=%0b, required 0/0/0/0/1",
                 ov[0], od[0], odig[0], oerr[0], ir[0]);
      end
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    push_exp(0, 32'h3, 4'd1, 1'b0);
    send_str(0, "3\r");
    wait_drain();

    out_ready = 1'b0;
    send_str(0, "9\r");
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ov[0] !== 1'b0 || od[0] !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_hold: got valid=%0b data=%h, required 0/0", ov[0], od[0]);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_bad_char();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_word();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
